alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-002 clk  input  1  system clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  block accepts requester N this cycle.
REQ-006 reqN_src1, reqN_src2  input  32 each  signed operands (Rs, Rt) of requester N.
REQ-007 reqN_funct  input  6  R-type function code of requester N.
REQ-008 reqN_shamt  input  5  shift amount of requester N.
REQ-009 rspN_valid  output  1  result for requester N is available.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rsp_result  output  32  result of the current transaction, shared by both requesters.
REQ-012 rsp_overflow  output  1  overflow flag of the current transaction.
REQ-013 alu_src1, alu_src2  output  32 each  to ALU read_data1/read_data2.
REQ-014 alu_funct  output  6 and alu_shamt  output  5  to ALU funct/shamt.
REQ-015 alu_aluop  output  2 and alu_alusrc  output  1  to ALU ALUOp/ALUSrc.
REQ-016 alu_immd  output  32  to ALU immd.
REQ-017 alu_result  input  32 and alu_overflow  input  1  from the ALU (combinational path).
REQ-018 busy  output  1  high whenever the FSM is not IDLE.
REQ-019 grant_id  output  1  index of the requester owning the current transaction.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-021 IDLE: reqN_ready SHALL be high only for the single winner among the valid requesters, and both SHALL be low if none is valid.
REQ-022 Arbitration SHALL be round-robin with a 1-bit priority pointer: if both are valid, pointer=N wins; if one is valid, it wins regardless of the pointer.
REQ-023 On accept (valid&ready), the block SHALL register src1/src2/funct/shamt, set grant_id=N, set pointer=~N and go to EXEC.
REQ-024 alu_src1/alu_src2/alu_funct/alu_shamt SHALL always be driven from the operand registers.
REQ-025 alu_aluop SHALL be constantly 2'b10, alu_alusrc constantly 0 and alu_immd constantly 0.
REQ-026 EXEC: on the closing edge, the block SHALL capture alu_result into rsp_result and go to RESP.
REQ-027 rsp_overflow SHALL equal alu_overflow when funct is 6'b100000 (ADD) and 0 otherwise.
REQ-028 RESP: rsp{grant_id}_valid SHALL be high, the other rsp valid low, and rsp_result/rsp_overflow SHALL be held stable until handshake.
REQ-029 RESP with rsp{grant_id}_ready high SHALL return to IDLE on that edge, and no new request SHALL be accepted in the same cycle.
REQ-030 Latency: accept at edge T SHALL yield rsp valid visible after edge T+1 (EXEC->RESP), i.e. the earliest response handshake is in the cycle after T+1; peak throughput is one op per 3 cycles.
REQ-031 reqN_ready SHALL be low in EXEC and RESP, and requests arriving then SHALL wait without loss (requester holds valid).
REQ-032 Unsupported funct codes SHALL be passed unchanged, and the transaction SHALL complete normally with whatever the ALU returns (0).
REQ-033 rspN_ready asserted while the corresponding rspN_valid is low SHALL be ignored.

Reset
REQ-034 While rst_n=0: state=IDLE, pointer=0, grant_id=0, operand registers=0, rsp_result=0, rsp_overflow=0, and all ready/valid outputs and busy low.
REQ-035 Reset asserted mid-transaction SHALL discard it immediately (asynchronous), and no response SHALL be issued after release.

Verification
REQ-036 req0 only: src1=5, src2=3, funct=ADD -> rsp0_valid with rsp_result=8, rsp_overflow=0 after 2 edges; rsp1_valid never high.
REQ-037 Both valid from reset with hold: grant order 0,1,0,1 across four transactions; grant_id and reqN_ready match.
REQ-038 req1: src1=0x7FFFFFFF, src2=1, ADD -> rsp_result=0x80000000, rsp_overflow=1; the same operands with SUB -> rsp_overflow=0.
REQ-039 rsp0_ready held low 5 cycles in RESP -> rsp_result and busy stable, req1_ready stays 0; release -> IDLE next edge, then req1 is accepted.
REQ-040 SLL: src2=1, shamt=4 -> 16; funct=6'b111111 -> result 0; SLT: -1 vs 2 -> 1.
REQ-041 rst_n pulsed low during EXEC -> all outputs at reset values asynchronously; no rsp valid after release until a new accept.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end letting two requesters share one combinational R-type ALU
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [5:0]  req0_funct,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [5:0]  req1_funct,
  input  logic [4:0]  req1_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic [1:0]  alu_aluop,
  output logic        alu_alusrc,
  output logic [31:0] alu_immd,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        busy,
  output logic        grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic ptr, win, accept, rsp_done;
  logic [31:0] src1_q, src2_q;
  logic [5:0] funct_q;
  logic [4:0] shamt_q;
  assign win = req0_valid && req1_valid ? ptr : req1_valid;
  assign req0_ready = state == IDLE && req0_valid && !win;
  assign req1_ready = state == IDLE && req1_valid && win;
  assign accept = req0_ready || req1_ready;
  assign rsp0_valid = state == RESP && !grant_id;
  assign rsp1_valid = state == RESP && grant_id;
  assign rsp_done = grant_id ? rsp1_ready : rsp0_ready;
  assign busy = state != IDLE;
  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;
  assign alu_funct = funct_q;
  assign alu_shamt = shamt_q;
  assign alu_aluop = 2'b10;
  assign alu_alusrc = 1'b0;
  assign alu_immd = 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      grant_id <= 1'b0;
      src1_q <= '0;
      src2_q <= '0;
      funct_q <= '0;
      shamt_q <= '0;
      rsp_result <= '0;
      rsp_overflow <= 1'b0;
    end else if (state == IDLE && accept) begin
      src1_q <= win ? req1_src1 : req0_src1;
      src2_q <= win ? req1_src2 : req0_src2;
      funct_q <= win ? req1_funct : req0_funct;
      shamt_q <= win ? req1_shamt : req0_shamt;
      grant_id <= win;
      ptr <= !win;
      state <= EXEC;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_overflow <= funct_q == 6'b100000 && alu_overflow;
      state <= RESP;
    end else if (state == RESP && rsp_done)
      state <= IDLE;
endmodule
